// File: rtl/conv_pkg.sv
// Shared width helpers, weight-bank indexing and fixed-point rounding for the
// K x K convolution MAC.
package conv_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int prod_width(input int dw, input int ww);
        return dw + ww;
    endfunction

    // One guard bit on top of the K*K-term growth absorbs the shifted bias.
    function automatic int acc_width(input int dw, input int ww, input int k);
        return dw + ww + clog2(k * k) + 1;
    endfunction

    // MSB of weight (r,c) in the flattened bank; element 0 sits at the top.
    function automatic int row_bit_hi(input int r, input int c, input int k, input int w);
        return (k * k - (r * k + c)) * w - 1;
    endfunction

    // Round half up, drop frac bits, clamp to a signed dw-bit range (frac >= 1).
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] v,
                                                     input int frac, input int dw);
        logic signed [63:0] r, hi, lo;
        r  = (v + (64'sd1 <<< (frac - 1))) >>> frac;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (r > hi) r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/conv_row_dot.sv
// Stage 1: K signed products of one kernel row, summed and registered with
// the row's valid/first/last tags; holds while en is low.
module conv_row_dot
    import conv_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int W_W    = 16,
    parameter int K      = 5,
    parameter int ACC_W  = 38
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [K*DATA_W-1:0]     d_row,
    input  logic [K*W_W-1:0]        w_row,
    output logic signed [ACC_W-1:0] sum,
    output logic                    s1_valid,
    output logic                    s1_first,
    output logic                    s1_last
);
    localparam int PROD_W = prod_width(DATA_W, W_W);

    logic signed [PROD_W-1:0] prod [K];
    logic signed [ACC_W-1:0]  dot;

    for (genvar c = 0; c < K; c++) begin : g_mul
        assign prod[c] = PROD_W'($signed(d_row[(K-c)*DATA_W-1 -: DATA_W]))
                       * PROD_W'($signed(w_row[(K-c)*W_W-1 -: W_W]));
    end

    always_comb begin
        dot = '0;
        for (int c = 0; c < K; c++) dot = dot + ACC_W'(prod[c]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum      <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                sum      <= dot;
                s1_first <= in_first;
                s1_last  <= in_last;
            end
        end
    end

endmodule

// File: rtl/conv_kxk_mac.sv
// K x K signed MAC window engine: one kernel row per beat, bias-added result
// every K beats. CONV_MAC_SAT_EN adds a round/saturate stage to DATA_W.
module conv_kxk_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int W_W    = 16,
    parameter int K      = 5,
    parameter int FRAC   = 15,
    localparam int ACC_W = acc_width(DATA_W, W_W, K),
`ifdef CONV_MAC_SAT_EN
    localparam int OUT_W = DATA_W
`else
    localparam int OUT_W = ACC_W
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [K*DATA_W-1:0]  d_in,
    input  logic [K*K*W_W-1:0]   w_in,
    input  logic [W_W-1:0]       b_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_W-1:0]     d_out,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int RC_W = clog2(K);
    localparam logic [RC_W-1:0] LAST_ROW = RC_W'(K - 1);

    logic                    stall, accept, load;
    logic [RC_W-1:0]         row_cnt;
    logic [K*W_W-1:0]        w_row;
    logic signed [ACC_W-1:0] s1_sum, acc, acc_next, bias_sh, full;
    logic                    s1_valid, s1_first, s1_last;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall && !clr;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      row_cnt <= '0;
        else if (clr)    row_cnt <= '0;
        else if (accept) row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + RC_W'(1);
    end

    always_comb begin
        w_row = '0;
        for (int c = 0; c < K; c++)
            w_row[(K-c)*W_W-1 -: W_W] = w_in[row_bit_hi(int'(row_cnt), c, K, W_W) -: W_W];
    end

    conv_row_dot #(
        .DATA_W (DATA_W),
        .W_W    (W_W),
        .K      (K),
        .ACC_W  (ACC_W)
    ) u_row_dot (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (!stall),
        .clr      (clr),
        .in_valid (accept),
        .in_first (row_cnt == '0),
        .in_last  (row_cnt == LAST_ROW),
        .d_row    (d_in),
        .w_row    (w_row),
        .sum      (s1_sum),
        .s1_valid (s1_valid),
        .s1_first (s1_first),
        .s1_last  (s1_last)
    );

    // The first row of a window restarts the sum, so windows run back to back.
    assign acc_next = (s1_first ? '0 : acc) + s1_sum;
    assign bias_sh  = ACC_W'($signed(b_in)) <<< FRAC;
    assign full     = acc_next + bias_sh;
    assign load     = s1_valid && s1_last && !stall && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      acc <= '0;
        else if (clr)                    acc <= '0;
        else if (s1_valid && !stall)     acc <= acc_next;
    end

`ifdef CONV_MAC_SAT_EN
    logic                    r_valid;
    logic signed [ACC_W-1:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_sum     <= '0;
            out_valid <= 1'b0;
            d_out     <= '0;
        end else if (!stall) begin
            r_valid   <= load;
            if (load) r_sum <= full;
            out_valid <= r_valid;
            if (r_valid) d_out <= OUT_W'(sat_round(64'(r_sum), FRAC, DATA_W));
        end
    end
`else
    // Without a stall the output is either empty or being consumed this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            d_out     <= '0;
        end else if (!stall) begin
            out_valid <= load;
            if (load) d_out <= full;
        end
    end
`endif

endmodule
